rng_lfsr_range: RTL and testbench

- Parametrised successor to the single-bit game random source.
- Free-running Fibonacci LFSR of selectable width, with runtime seed load and a request/valid handshake.
- Each request returns one uniformly distributed value in 0..RANGE-1, with optional no-immediate-repeat. Used to pick the next Bop-It command.
- Also exports the raw single-bit stream for existing consumers.

---
 rtl/rng_lfsr_range.sv | 186 ++++++++++++++++++
 tb/tb_rng_lfsr_range.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rng_lfsr_range.sv
// rng_lfsr_range: free-running Fibonacci LFSR with seed load and a
// request/valid handshake that returns uniformly distributed values in
// 0..RANGE-1 using rejection sampling with a bounded fallback.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-low
//   i_en         step the LFSR while IDLE
//   i_seed_load  load i_seed (zero substitutes SEED) at this edge
//   i_seed       seed value
//   i_req        draw request, sampled only in IDLE
//   o_valid      one-cycle strobe, o_rand has just been updated
//   o_rand       last drawn value, held until the next draw
//   o_lfsr       current LFSR state
//   o_bit        o_lfsr[WIDTH-1], legacy serial stream
//   o_busy       high while a draw is in progress
module rng_lfsr_range #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned SEED      = 1,
    parameter int unsigned OUT_W     = 2,
    parameter int unsigned RANGE     = 4,
    parameter int unsigned MAX_TRIES = 8,
    parameter int unsigned NO_REPEAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_seed_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_req,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_rand,
    output logic [WIDTH-1:0] o_lfsr,
    output logic             o_bit,
    output logic             o_busy
);

    // One extra bit so RANGE == 2^OUT_W compares correctly.
    localparam int unsigned CW = OUT_W + 1;
    localparam int unsigned TW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [OUT_W-1:0] rand_q, rand_d;
    logic [OUT_W-1:0] last_q, last_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic             valid_q, valid_d;

    logic             feedback;
    logic [WIDTH-1:0] lfsr_step;
    logic [WIDTH-1:0] seed_val;
    logic [OUT_W-1:0] cand;
    logic [CW-1:0]    cand_ext;
    logic             in_range;
    logic             repeat_hit;
    logic [OUT_W-1:0] fold;
    logic [OUT_W-1:0] fallback;
    logic [TW-1:0]    tries_inc;

    // Parameter legality, rejected at elaboration.
    if (SEED == 0) begin : g_bad_seed
        $error("rng_lfsr_range: SEED must be nonzero");
    end
    if (!((RANGE > (1 << (OUT_W - 1))) && (RANGE <= (1 << OUT_W)))) begin : g_bad_range
        $error("rng_lfsr_range: RANGE must satisfy 2^(OUT_W-1) < RANGE <= 2^OUT_W");
    end
    if ((MAX_TRIES < 1) || (MAX_TRIES > 15)) begin : g_bad_tries
        $error("rng_lfsr_range: MAX_TRIES must be 1..15");
    end
    if (OUT_W > WIDTH) begin : g_bad_outw
        $error("rng_lfsr_range: OUT_W must not exceed WIDTH");
    end

    // Maximal-length tap sets per width.
    if (WIDTH == 8) begin : g_tap8
        assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    end else if (WIDTH == 16) begin : g_tap16
        assign feedback = lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3];
    end else if (WIDTH == 24) begin : g_tap24
        assign feedback = lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16];
    end else if (WIDTH == 32) begin : g_tap32
        assign feedback = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];
    end else begin : g_tap_bad
        assign feedback = 1'b0;
        $error("rng_lfsr_range: WIDTH must be 8, 16, 24 or 32");
    end

    assign lfsr_step = {lfsr_q[WIDTH-2:0], feedback};
    assign seed_val  = (i_seed == '0) ? WIDTH'(SEED) : i_seed;

    // Candidate evaluation and fallback value for the current DRAW edge.
    always_comb begin
        cand       = lfsr_q[OUT_W-1:0];
        cand_ext   = CW'(cand);
        in_range   = cand_ext < CW'(RANGE);
        repeat_hit = (NO_REPEAT != 0) && (cand == last_q);
        fold       = in_range ? cand : OUT_W'(cand_ext - CW'(RANGE));
        fallback   = fold;
        if ((NO_REPEAT != 0) && (fold == last_q)) begin
            fallback = ((CW'(last_q) + CW'(1)) == CW'(RANGE)) ? '0 : OUT_W'(last_q + OUT_W'(1));
        end
        tries_inc  = tries_q + TW'(1);
    end

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        rand_d  = rand_q;
        last_d  = last_q;
        tries_d = tries_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_en) begin
                    lfsr_d = lfsr_step;
                end
                if (i_req) begin
                    state_d = DRAW;
                    tries_d = '0;
                end
            end
            DRAW: begin
                lfsr_d = lfsr_step;
                if (in_range && !repeat_hit) begin
                    rand_d  = cand;
                    last_d  = cand;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (tries_inc == TW'(MAX_TRIES)) begin
                    rand_d  = fallback;
                    last_d  = fallback;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tries_d = tries_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        // Seed load overrides any step, in either state.
        if (i_seed_load) begin
            lfsr_d = seed_val;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q  <= WIDTH'(SEED);
            rand_q  <= '0;
            last_q  <= '0;
            tries_q <= '0;
            valid_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            rand_q  <= rand_d;
            last_q  <= last_d;
            tries_q <= tries_d;
            valid_q <= valid_d;
        end
    end

    assign o_valid = valid_q;
    assign o_rand  = rand_q;
    assign o_lfsr  = lfsr_q;
    assign o_bit   = lfsr_q[WIDTH-1];
    assign o_busy  = (state_q == DRAW);

endmodule

// File: tb/tb_rng_lfsr_range.sv
// Directed bench for rng_lfsr_range. Instances 0..3 are WIDTH=8, OUT_W=2,
// RANGE=3; index bit 1 selects MAX_TRIES=1 (else 8), bit 0 selects
// NO_REPEAT. A fifth instance uses the default 16-bit configuration.
module tb_rng_lfsr_range;

    logic       clk;
    logic       rst;
    logic [3:0] en;
    logic [3:0] sload;
    logic [3:0] req;
    logic [7:0] seed  [4];
    logic       valid [4];
    logic [1:0] rnd   [4];
    logic [7:0] lfsr  [4];
    logic       bitv  [4];
    logic       busy  [4];

    logic        en_e;
    logic        valid_e;
    logic [1:0]  rnd_e;
    logic [15:0] lfsr_e;
    logic        bit_e;
    logic        busy_e;

    int errors = 0;
    int checks = 0;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        rng_lfsr_range #(
            .WIDTH    (8),
            .SEED     (1),
            .OUT_W    (2),
            .RANGE    (3),
            .MAX_TRIES((k >= 2) ? 1 : 8),
            .NO_REPEAT(k % 2)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .i_en       (en[k]),
            .i_seed_load(sload[k]),
            .i_seed     (seed[k]),
            .i_req      (req[k]),
            .o_valid    (valid[k]),
            .o_rand     (rnd[k]),
            .o_lfsr     (lfsr[k]),
            .o_bit      (bitv[k]),
            .o_busy     (busy[k])
        );
    end

    rng_lfsr_range dut_e (
        .clk        (clk),
        .rst        (rst),
        .i_en       (en_e),
        .i_seed_load(1'b0),
        .i_seed     (16'h0000),
        .i_req      (1'b0),
        .o_valid    (valid_e),
        .o_rand     (rnd_e),
        .o_lfsr     (lfsr_e),
        .o_bit      (bit_e),
        .o_busy     (busy_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_seq [6];
        int zero_hits;
        int first_ret;
        int vcount;
        int consec;
        logic prev_v;

        exp_seq[0] = 8'h02; exp_seq[1] = 8'h04; exp_seq[2] = 8'h08;
        exp_seq[3] = 8'h11; exp_seq[4] = 8'h23; exp_seq[5] = 8'h47;

        rst = 1'b0; en = '0; sload = '0; req = '0; en_e = 1'b0;
        for (int k = 0; k < 4; k++) seed[k] = 8'h00;
        #12;
        chk("rst_lfsr",  32'(lfsr[0]), 32'h01);
        chk("rst_rand",  32'(rnd[0]), 32'h0);
        chk("rst_valid", 32'(valid[0]), 32'h0);
        chk("rst_busy",  32'(busy[0]), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Free-running steps from SEED.
        en[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("step%0d_lfsr", i), 32'(lfsr[0]), 32'(exp_seq[i]));
            chk($sformatf("step%0d_bit", i), 32'(bitv[0]), 32'h0);
        end
        en[0] = 1'b0; sload[0] = 1'b1; seed[0] = 8'h01;
        tick();
        sload[0] = 1'b0; en[0] = 1'b1;
        zero_hits = 0; first_ret = 0;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (lfsr[0] == 8'h00) zero_hits++;
            if (lfsr[0] == 8'h01 && first_ret == 0) first_ret = i + 1;
        end
        en[0] = 1'b0;
        chk("period_zero", 32'(zero_hits), 32'd0);
        chk("period_len",  32'(first_ret), 32'd255);

        en_e = 1'b1;
        repeat (8) tick();
        en_e = 1'b0;
        chk("w16_lfsr", 32'(lfsr_e), 32'h0111);

        // Seed load: zero substitution and priority over step.
        sload[0] = 1'b1; seed[0] = 8'h00;
        tick();
        chk("seed_zero", 32'(lfsr[0]), 32'h01);
        en[0] = 1'b1; seed[0] = 8'h5A;
        tick();
        chk("seed_wins", 32'(lfsr[0]), 32'h5A);
        en[0] = 1'b0; sload[0] = 1'b0;

        // Draws from 0x23 on all four instances.
        sload = 4'hF;
        for (int k = 0; k < 4; k++) seed[k] = 8'h23;
        tick();
        sload = '0;
        req = 4'hF;
        tick();
        req = '0;
        chk("d0_busy",  32'(busy[0]), 32'h1);
        chk("d0_valid", 32'(valid[0]), 32'h0);
        chk("d0_lfsr",  32'(lfsr[0]), 32'h23);
        tick();
        chk("d1_busy",  32'(busy[0]), 32'h1);
        chk("d1_valid", 32'(valid[0]), 32'h0);
        chk("d1_lfsr",  32'(lfsr[0]), 32'h47);
        chk("fb_valid", 32'(valid[2]), 32'h1);
        chk("fb_rand",  32'(rnd[2]), 32'h0);
        chk("fb_busy",  32'(busy[2]), 32'h0);
        chk("fbnr_valid", 32'(valid[3]), 32'h1);
        chk("fbnr_rand",  32'(rnd[3]), 32'h1);
        tick();
        chk("d2_busy",  32'(busy[0]), 32'h1);
        chk("d2_valid", 32'(valid[0]), 32'h0);
        chk("fb_valid_drop", 32'(valid[2]), 32'h0);
        tick();
        chk("d3_valid", 32'(valid[0]), 32'h1);
        chk("d3_rand",  32'(rnd[0]), 32'h2);
        chk("d3_busy",  32'(busy[0]), 32'h0);
        chk("d3_lfsr",  32'(lfsr[0]), 32'h1C);
        chk("nr_first_rand", 32'(rnd[1]), 32'h2);
        tick();
        chk("d4_valid", 32'(valid[0]), 32'h0);

        // No-repeat rejection: last=2, candidate 2 then 0.
        sload[1] = 1'b1; seed[1] = 8'h8E;
        tick();
        sload[1] = 1'b0; req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        tick();
        chk("nr_rej_valid", 32'(valid[1]), 32'h0);
        chk("nr_rej_busy",  32'(busy[1]), 32'h1);
        tick();
        chk("nr_acc_valid", 32'(valid[1]), 32'h1);
        chk("nr_acc_rand",  32'(rnd[1]), 32'h0);

        // Asynchronous reset in the second DRAW cycle.
        sload[0] = 1'b1; seed[0] = 8'h23;
        tick();
        sload[0] = 1'b0; req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_lfsr",  32'(lfsr[0]), 32'h01);
        chk("arst_rand",  32'(rnd[0]), 32'h0);
        chk("arst_busy",  32'(busy[0]), 32'h0);
        chk("arst_valid", 32'(valid[0]), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid[0]) vcount++;
        end
        chk("arst_no_valid", 32'(vcount), 32'd0);

        // Request held high: one strobe per IDLE sampling, never back-to-back.
        sload[0] = 1'b1; seed[0] = 8'h23;
        tick();
        sload[0] = 1'b0; req[0] = 1'b1;
        vcount = 0; consec = 0; prev_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid[0]) vcount++;
            if (valid[0] && prev_v) consec++;
            prev_v = valid[0];
        end
        req[0] = 1'b0;
        chk("hold_count",  32'(vcount), 32'd4);
        chk("hold_consec", 32'(consec), 32'd0);
        chk("hold_rand",   32'(rnd[0]), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
